// File: rtl/red_region_scheduler.sv
// red_region_scheduler: snoops the accepted RGB444 pixel stream and counts red
// pixels in the left, centre and right column thirds of each frame. At the end
// of a good frame it picks a steering direction and hands it to the motor
// driver with a valid/ack handshake.
// Optional build macro RED_REGION_HYST_EN: a direction change is reported only
// after two consecutive good frames agree on the new direction.
module red_region_scheduler #(
    parameter int unsigned IMG_W        = 320,
    parameter int unsigned FRAME_PIXELS = 76800,
    parameter int unsigned CNT_W        = 17,
    parameter logic [3:0]  R_MIN        = 4'd8,
    parameter logic [3:0]  GB_MAX       = 4'd6,
    parameter int unsigned MIN_PIXELS   = 500
) (
    input  logic             clk_25_vga,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pix_ready,
    input  logic             pix_sop,
    input  logic             pix_eop,
    input  logic [11:0]      pix_data,
    input  logic             result_ack,
    output logic             result_valid,
    output logic [1:0]       direction,
    output logic [CNT_W-1:0] left_cnt,
    output logic [CNT_W-1:0] centre_cnt,
    output logic [CNT_W-1:0] right_cnt,
    output logic [CNT_W-1:0] red_total,
    output logic [7:0]       frame_drops
);
    localparam int unsigned      XW          = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [XW-1:0]    X_LAST      = XW'(IMG_W - 1);
    localparam logic [XW-1:0]    X_THIRD     = XW'(IMG_W / 3);
    localparam logic [XW-1:0]    X_TWO_THIRD = XW'((2 * IMG_W) / 3);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] FRAME_CNT   = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_PIXELS);
    localparam logic [1:0]       DIR_NONE    = 2'b00;
    localparam logic [1:0]       DIR_LEFT    = 2'b01;
    localparam logic [1:0]       DIR_CENTRE  = 2'b10;
    localparam logic [1:0]       DIR_RIGHT   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_SOP, S_ACCUM, S_DECIDE, S_REPORT
    } state_t;

    state_t           state;
    logic [XW-1:0]    x_cnt;
    logic [CNT_W-1:0] beat_cnt, acc_l, acc_c, acc_r;

    logic             sop_beat_c, red_c, frame_ok_c, accept_c;
    logic [XW-1:0]    x_base_c, x_next_c;
    logic [CNT_W-1:0] beat_base_c, l_base_c, c_base_c, r_base_c;
    logic [CNT_W-1:0] beat_next_c, l_next_c, c_next_c, r_next_c;
    logic [CNT_W-1:0] dec_max_c, dec_total_c;
    logic [CNT_W+1:0] dec_sum_c;
    logic [1:0]       dec_dir_c;
    logic [7:0]       drops_sop_c, drops_eop_c;

`ifdef RED_REGION_HYST_EN
    logic       has_reported;
    logic       pend_valid;
    logic [1:0] pend_dir;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Per-beat accumulator update; a sop beat restarts from cleared counters.
    always_comb begin
        sop_beat_c  = pix_ready & pix_sop;
        red_c       = (pix_data[11:8] >= R_MIN) && (pix_data[7:4] < GB_MAX) &&
                      (pix_data[3:0] < GB_MAX);
        x_base_c    = sop_beat_c ? '0 : x_cnt;
        beat_base_c = sop_beat_c ? '0 : beat_cnt;
        l_base_c    = sop_beat_c ? '0 : acc_l;
        c_base_c    = sop_beat_c ? '0 : acc_c;
        r_base_c    = sop_beat_c ? '0 : acc_r;
        x_next_c    = (x_base_c == X_LAST) ? '0 : x_base_c + XW'(1);
        beat_next_c = sat_inc(beat_base_c);
        l_next_c    = (red_c && (x_base_c < X_THIRD)) ? sat_inc(l_base_c) : l_base_c;
        c_next_c    = (red_c && (x_base_c >= X_THIRD) && (x_base_c < X_TWO_THIRD)) ?
                      sat_inc(c_base_c) : c_base_c;
        r_next_c    = (red_c && (x_base_c >= X_TWO_THIRD)) ? sat_inc(r_base_c) : r_base_c;
        frame_ok_c  = (beat_next_c == FRAME_CNT);
        // Restarting a frame mid-accumulation drops it; a short/long eop drops too.
        drops_sop_c = (state == S_ACCUM && sop_beat_c) ? sat_inc8(frame_drops) : frame_drops;
        drops_eop_c = sat_inc8(drops_sop_c);
    end

    // Direction decision: largest region wins, ties go CENTRE > LEFT > RIGHT.
    always_comb begin
        dec_dir_c = DIR_CENTRE;
        dec_max_c = acc_c;
        if (!(acc_c >= acc_l && acc_c >= acc_r)) begin
            if (acc_l >= acc_r) begin
                dec_dir_c = DIR_LEFT;
                dec_max_c = acc_l;
            end else begin
                dec_dir_c = DIR_RIGHT;
                dec_max_c = acc_r;
            end
        end
        if (dec_max_c < MIN_CNT) dec_dir_c = DIR_NONE;
        dec_sum_c   = {2'b00, acc_l} + {2'b00, acc_c} + {2'b00, acc_r};
        dec_total_c = (dec_sum_c > {2'b00, CNT_MAX}) ? CNT_MAX : dec_sum_c[CNT_W-1:0];
`ifdef RED_REGION_HYST_EN
        accept_c = !has_reported || (dec_dir_c == direction) ||
                   (pend_valid && (pend_dir == dec_dir_c));
`else
        accept_c = 1'b1;
`endif
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk_25_vga or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            x_cnt        <= '0;
            beat_cnt     <= '0;
            acc_l        <= '0;
            acc_c        <= '0;
            acc_r        <= '0;
            result_valid <= 1'b0;
            direction    <= DIR_NONE;
            left_cnt     <= '0;
            centre_cnt   <= '0;
            right_cnt    <= '0;
            red_total    <= '0;
            frame_drops  <= '0;
`ifdef RED_REGION_HYST_EN
            has_reported <= 1'b0;
            pend_valid   <= 1'b0;
            pend_dir     <= DIR_NONE;
`endif
        end else if (!enable) begin
            state        <= S_IDLE;
            result_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_WAIT_SOP;
                S_WAIT_SOP: begin
                    if (sop_beat_c) begin
                        x_cnt    <= x_next_c;
                        beat_cnt <= beat_next_c;
                        acc_l    <= l_next_c;
                        acc_c    <= c_next_c;
                        acc_r    <= r_next_c;
                        if (!pix_eop)        state <= S_ACCUM;
                        else if (frame_ok_c) state <= S_DECIDE;
                        else                 frame_drops <= sat_inc8(frame_drops);
                    end
                end
                S_ACCUM: begin
                    if (pix_ready) begin
                        x_cnt    <= x_next_c;
                        beat_cnt <= beat_next_c;
                        acc_l    <= l_next_c;
                        acc_c    <= c_next_c;
                        acc_r    <= r_next_c;
                        if (pix_eop && frame_ok_c) begin
                            state       <= S_DECIDE;
                            frame_drops <= drops_sop_c;
                        end else if (pix_eop) begin
                            state       <= S_WAIT_SOP;
                            frame_drops <= drops_eop_c;
                        end else begin
                            frame_drops <= drops_sop_c;
                        end
                    end
                end
                S_DECIDE: begin
                    if (accept_c) begin
                        left_cnt     <= acc_l;
                        centre_cnt   <= acc_c;
                        right_cnt    <= acc_r;
                        red_total    <= dec_total_c;
                        direction    <= dec_dir_c;
                        result_valid <= 1'b1;
                        state        <= S_REPORT;
                    end else begin
                        state <= S_WAIT_SOP;
                    end
`ifdef RED_REGION_HYST_EN
                    if (accept_c) begin
                        has_reported <= 1'b1;
                        pend_valid   <= 1'b0;
                    end else begin
                        pend_valid <= 1'b1;
                        pend_dir   <= dec_dir_c;
                    end
`endif
                end
                S_REPORT: begin
                    if (sop_beat_c) frame_drops <= sat_inc8(frame_drops);
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        state        <= S_WAIT_SOP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_red_region_scheduler.sv
// Directed bench for red_region_scheduler with a 12x4 test frame.
module tb_red_region_scheduler;
    localparam int unsigned IMG_W        = 12;
    localparam int unsigned FRAME_PIXELS = 48;
    localparam int unsigned CNT_W        = 17;
    localparam int unsigned MIN_PIXELS   = 3;

    logic             clk_25_vga = 1'b0;
    logic             reset_n    = 1'b0;
    logic             enable     = 1'b0;
    logic             pix_ready  = 1'b0;
    logic             pix_sop    = 1'b0;
    logic             pix_eop    = 1'b0;
    logic [11:0]      pix_data   = 12'h000;
    logic             result_ack = 1'b0;
    logic             result_valid;
    logic [1:0]       direction;
    logic [CNT_W-1:0] left_cnt, centre_cnt, right_cnt, red_total;
    logic [7:0]       frame_drops;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_drops = 0;

    typedef struct {
        logic [11:0] mask;
        int          rows;
        bit          gappy;
        int          l, c, r, t;
        logic [1:0]  dir;
    } vec_t;

    vec_t tbl[8];

    red_region_scheduler #(
        .IMG_W(IMG_W), .FRAME_PIXELS(FRAME_PIXELS), .CNT_W(CNT_W),
        .R_MIN(4'd8), .GB_MAX(4'd6), .MIN_PIXELS(MIN_PIXELS)
    ) dut (
        .clk_25_vga(clk_25_vga), .reset_n(reset_n), .enable(enable),
        .pix_ready(pix_ready), .pix_sop(pix_sop), .pix_eop(pix_eop),
        .pix_data(pix_data), .result_ack(result_ack),
        .result_valid(result_valid), .direction(direction),
        .left_cnt(left_cnt), .centre_cnt(centre_cnt), .right_cnt(right_cnt),
        .red_total(red_total), .frame_drops(frame_drops)
    );

    always #5 clk_25_vga = ~clk_25_vga;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25_vga);
        #1;
    endtask

    task automatic check_out(input string tag, input int l, input int c, input int r,
                             input int t, input logic [1:0] d, input logic v);
        check({tag, ".valid"}, 32'(result_valid), 32'(v));
        check({tag, ".dir"},   32'(direction), 32'(d));
        check({tag, ".left"},  32'(left_cnt), l);
        check({tag, ".centre"},32'(centre_cnt), c);
        check({tag, ".right"}, 32'(right_cnt), r);
        check({tag, ".total"}, 32'(red_total), t);
        check({tag, ".drops"}, 32'(frame_drops), exp_drops);
    endtask

    // Red pixels alternate a saturated and a just-qualifying value; non-red
    // pixels include values that miss each threshold by one step.
    function automatic logic [11:0] pixel(input logic [11:0] mask, input int rows, input int i);
        int col = i % int'(IMG_W);
        int row = i / int'(IMG_W);
        if (mask[col] && row < rows) return (i % 2 == 1) ? 12'hF00 : 12'h855;
        case (i % 4)
            0:       return 12'h000;
            1:       return 12'h760;
            2:       return 12'h865;
            default: return 12'h856;
        endcase
    endfunction

    // Idle cycles carry junk sop/eop/red data that must be ignored.
    task automatic send_frame(input logic [11:0] mask, input int rows, input int len,
                              input bit do_eop, input bit gappy);
        for (int i = 0; i < len; i++) begin
            for (int g = 0; gappy && g < 3 && $urandom_range(1, 0) == 1; g++) begin
                pix_ready = 1'b0; pix_sop = 1'b1; pix_eop = 1'b1; pix_data = 12'hF00;
                tick();
            end
            pix_ready = 1'b1;
            pix_sop   = (i == 0);
            pix_eop   = do_eop && (i == len - 1);
            pix_data  = pixel(mask, rows, i);
            tick();
        end
        pix_ready = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0; pix_data = 12'h000;
    endtask

    task automatic frame_and_report(input string tag, input logic [11:0] mask, input int rows,
                                    input bit gappy, input int l, input int c, input int r,
                                    input int t, input logic [1:0] d, input bit do_ack);
        send_frame(mask, rows, int'(FRAME_PIXELS), 1'b1, gappy);
        check({tag, ".lat1"}, 32'(result_valid), 0);
        tick();
        check_out(tag, l, c, r, t, d, 1'b1);
        if (do_ack) begin
            result_ack = 1'b1;
            tick();
            result_ack = 1'b0;
            check({tag, ".ack"}, 32'(result_valid), 0);
        end
    endtask

    // Enable drop from REPORT and mid-frame; latched result must survive.
    task automatic enable_test(input logic [11:0] mask, input int l, input int c, input int r,
                               input int t, input logic [1:0] d);
        enable = 1'b0;
        tick();
        check_out("en_off_report", l, c, r, t, d, 1'b0);
        enable = 1'b1;
        tick();
        send_frame(12'h0F0, 4, 20, 1'b0, 1'b0);
        enable = 1'b0;
        tick();
        check_out("en_off_midframe", l, c, r, t, d, 1'b0);
        enable = 1'b1;
        tick();
        frame_and_report("en_resume", mask, 4, 1'b0, l, c, r, t, d, 1'b0);
    endtask

    initial begin
        tbl[0] = '{12'h00F, 4, 1'b0, 16, 0,  0, 16, 2'd1};
        tbl[1] = '{12'h110, 4, 1'b0,  0, 4,  4,  8, 2'd2};
        tbl[2] = '{12'h800, 2, 1'b0,  0, 0,  2,  2, 2'd0};
        tbl[3] = '{12'h00F, 4, 1'b1, 16, 0,  0, 16, 2'd1};
        tbl[4] = '{12'hFFF, 1, 1'b0,  4, 4,  4, 12, 2'd2};
        tbl[5] = '{12'hF07, 3, 1'b1,  9, 0, 12, 21, 2'd3};
        tbl[6] = '{12'h30C, 4, 1'b0,  8, 0,  8, 16, 2'd1};
        tbl[7] = '{12'h020, 3, 1'b0,  0, 3,  0,  3, 2'd2};

        repeat (3) @(posedge clk_25_vga);
        #1;
        check_out("reset", 0, 0, 0, 0, 2'd0, 1'b0);
        reset_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();

`ifdef RED_REGION_HYST_EN
        frame_and_report("hyst_left", 12'h00F, 4, 1'b0, 16, 0, 0, 16, 2'd1, 1'b1);
        send_frame(12'hF00, 4, int'(FRAME_PIXELS), 1'b1, 1'b0);
        tick();
        check_out("hyst_right1", 16, 0, 0, 16, 2'd1, 1'b0);
        frame_and_report("hyst_right2", 12'hF00, 4, 1'b0, 0, 0, 16, 16, 2'd3, 1'b0);
        enable_test(12'hF00, 0, 0, 16, 16, 2'd3);
`else
        foreach (tbl[k]) begin
            frame_and_report($sformatf("vec%0d", k), tbl[k].mask, tbl[k].rows, tbl[k].gappy,
                             tbl[k].l, tbl[k].c, tbl[k].r, tbl[k].t, tbl[k].dir, 1'b1);
        end

        // Short frame is dropped, then a restart sop mid-frame is dropped.
        send_frame(12'h00F, 4, 40, 1'b1, 1'b0);
        tick();
        tick();
        exp_drops = 1;
        check("short.valid", 32'(result_valid), 0);
        check("short.drops", 32'(frame_drops), exp_drops);
        send_frame(12'h00F, 4, 20, 1'b0, 1'b0);
        exp_drops = 2;
        frame_and_report("restart", 12'h110, 4, 1'b0, 0, 4, 4, 8, 2'd2, 1'b0);

        // Unacknowledged result holds while three frames are skipped.
        for (int f = 0; f < 3; f++) send_frame(12'h00F, 4, int'(FRAME_PIXELS), 1'b1, 1'b0);
        tick();
        exp_drops = 5;
        check_out("hold", 0, 4, 4, 8, 2'd2, 1'b1);
        result_ack = 1'b1;
        tick();
        check("hold.ack", 32'(result_valid), 0);

        // Ack held high: the decision is consumed after one cycle of valid.
        frame_and_report("ack_held", 12'h00F, 4, 1'b0, 16, 0, 0, 16, 2'd1, 1'b0);
        tick();
        check_out("ack_held.after", 16, 0, 0, 16, 2'd1, 1'b0);
        result_ack = 1'b0;

        frame_and_report("pre_en", 12'h00F, 4, 1'b0, 16, 0, 0, 16, 2'd1, 1'b0);
        enable_test(12'h00F, 16, 0, 0, 16, 2'd1);
`endif

        // Asynchronous reset in the middle of a frame.
        send_frame(12'h00F, 4, 10, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        exp_drops = 0;
        check_out("mid_reset", 0, 0, 0, 0, 2'd0, 1'b0);
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
